load_buf: RTL and testbench
===========================

Name: load_buf

Overview:
- Buffers load requests coming from the load FU and issues them in program order to the data-memory read port.
- Holds each returned read datum until the load is no longer speculative, then hands it to writeback.
- It is the read-side counterpart of the store buffer and uses the same speculation-level and branch-resolution interface.
- Ordering against older pending stores is resolved upstream before a load enters this block.

Parameters:
- INST_ID_BIT, 8, instruction id width
- ADDR_BIT, 16, memory address width
- DATA_BIT, 16, memory data width
- REG_ID_BIT, 4, destination register id width
- BUF_DEPTH, 8, entries (power of two)
- SPEC_DEPTH, 4, maximum unresolved branches
- SPEC_LEVEL_BIT, $clog2(SPEC_DEPTH)+1, speculation level width
- PTR_BIT, $clog2(BUF_DEPTH), pointer width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld / in_rdy  in / out  1 / 1  load request handshake
- in_id  in  INST_ID_BIT  instruction id
- in_addr  in  ADDR_BIT  load address
- in_dst  in  REG_ID_BIT  destination register
- in_spec_level  in  SPEC_LEVEL_BIT  speculation level at entry
- mem_req_vld / mem_req_rdy  out / in  1 / 1  memory read request handshake
- mem_req_addr  out  ADDR_BIT  read address
- mem_resp_vld  in  1  read data valid; responses return in request order; always accepted
- mem_resp_data  in  DATA_BIT  read data
- out_vld / out_rdy  out / in  1 / 1  writeback handshake
- out_id  out  INST_ID_BIT  instruction id
- out_dst  out  REG_ID_BIT  destination register
- out_data  out  DATA_BIT  loaded data
- br_pred_vld  in  1  branch resolved this cycle
- br_pred_succ  in  1  prediction correct
- br_pred_fail_level  in  SPEC_LEVEL_BIT  on fail, kill entries at level >= this
- br_pred_succ_nxt_levels  in  SPEC_LEVEL_BIT*(SPEC_DEPTH+1)  on success, new level = slice[old level]

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low.
- Reset values: wptr, iptr, rsptr, rptr = 0; cnt = 0; all live/done flags = 0. Outputs: in_rdy = 1, mem_req_vld = 0, out_vld = 0. Data fields are not reset.
- Storage: circular buffer. Per entry: live, done, id, addr, dst, data, spec_level.
- Pointers:
  - wptr: allocate.
  - iptr: next entry to issue.
  - rsptr: next entry to receive a response.
  - rptr: head / retire.
  - cnt: PTR_BIT+1 bits, counts occupied slots.
- Allocate:
  - in_rdy = (cnt < BUF_DEPTH).
  - On in_vld & in_rdy: entry[wptr] gets live=1, done=0, and all fields; wptr++ (wraps mod BUF_DEPTH).
  - Same-cycle allocation is never killed by a branch failure; the FU filters that case.
- Issue:
  - mem_req_vld = (iptr != wptr) || (cnt == BUF_DEPTH && iptr == wptr && !issued_all).
  - Implement issue with a separate unissued count, PTR_BIT+1 bits.
  - mem_req_addr = addr[iptr]. On handshake, iptr++.
  - Killed entries are still issued; reads have no side effects. This keeps the response mapping 1:1.
  - Issue latency: an entry allocated in cycle N can issue in cycle N+1 at the earliest.
- Response:
  - On mem_resp_vld: data[rsptr] <= mem_resp_data; done[rsptr] <= 1; rsptr++.
  - A response with no outstanding request is a protocol error; the block ignores it and does not advance rsptr.
- Retire:
  - out_vld = cnt > 0 && live[rptr] && done[rptr] && spec_level[rptr] == 0.
  - out_* are driven from entry[rptr].
  - On out_vld & out_rdy: live=0, done=0, rptr++, cnt--.
- Reclaim killed head:
  - If cnt > 0 && !live[rptr] && done[rptr]: done=0, rptr++, cnt--, without asserting out_vld.
  - A killed head whose response has not returned blocks the head until the response arrives.
- cnt update: +1 on allocate, −1 on retire or reclaim; both in one cycle leaves cnt unchanged.
- Branch fail (br_pred_vld & !br_pred_succ): every live entry with spec_level >= br_pred_fail_level gets live=0. Its done/data and pointers are unaffected.
- Branch success (br_pred_vld & br_pred_succ): every live entry's spec_level <= nxt_levels[spec_level]. The remap is not applied to the entry being written this cycle.
- Simultaneous events:
  - Response and kill to the same entry in one cycle: done=1 and live=0 both apply.
  - Retire and branch success in one cycle: retire uses the pre-update level.
- Wrap-around: all pointers wrap modulo BUF_DEPTH. The full state is cnt == BUF_DEPTH, not wptr == rptr.

Test Plan:
- Single load, non-speculative: in addr=0x0010, dst=3, level 0; memory returns 0xBEEF 2 cycles after request -> mem_req_addr=0x0010 one cycle after accept; out_vld with data=0xBEEF, dst=3 the cycle after the response.
- Speculative hold: load at level 1, response 0x1234 returns; out_vld stays 0. Branch success maps 1->0 -> out_vld=1 next cycle with 0x1234.
- Flush: loads A (level 0), B (level 2), C (level 2), all responses returned; branch fail at level 2 -> only A written back. B and C are reclaimed one per cycle; cnt returns to 0; out_vld never asserts for B or C.
- Flush before response: kill an issued load at level 1, response arrives 5 cycles later -> head stalls until the response, then is reclaimed; a younger level-0 load behind it retires after.
- Full and wrap: push 8 loads with mem_req_rdy=0 -> in_rdy=0 at cnt=8. Release memory and drain, then push 8 more -> ids come out in order across the pointer wrap.
- Backpressure: out_rdy=0 with 3 completed level-0 loads -> out_id is stable at the oldest. Raise out_rdy -> three consecutive writebacks in program order.

Source files
------------

// File: rtl/load_buf.sv
// In-order load buffer: issues loads to the data-memory read port in program order and
// holds each returned datum until it is non-speculative, then hands it to writeback.
module load_buf #(
  parameter int INST_ID_BIT    = 8,
  parameter int ADDR_BIT       = 16,
  parameter int DATA_BIT       = 16,
  parameter int REG_ID_BIT     = 4,
  parameter int BUF_DEPTH      = 8,
  parameter int SPEC_DEPTH     = 4,
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  parameter int PTR_BIT        = $clog2(BUF_DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_vld,
  output logic                                     in_rdy,
  input  logic [INST_ID_BIT-1:0]                   in_id,
  input  logic [ADDR_BIT-1:0]                      in_addr,
  input  logic [REG_ID_BIT-1:0]                    in_dst,
  input  logic [SPEC_LEVEL_BIT-1:0]                in_spec_level,
  output logic                                     mem_req_vld,
  input  logic                                     mem_req_rdy,
  output logic [ADDR_BIT-1:0]                      mem_req_addr,
  input  logic                                     mem_resp_vld,
  input  logic [DATA_BIT-1:0]                      mem_resp_data,
  output logic                                     out_vld,
  input  logic                                     out_rdy,
  output logic [INST_ID_BIT-1:0]                   out_id,
  output logic [REG_ID_BIT-1:0]                    out_dst,
  output logic [DATA_BIT-1:0]                      out_data,
  input  logic                                     br_pred_vld,
  input  logic                                     br_pred_succ,
  input  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level,
  input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels
);

  localparam logic [PTR_BIT:0] FULL_CNT = (PTR_BIT + 1)'(BUF_DEPTH);
  localparam logic [PTR_BIT-1:0] PTR_ONE = PTR_BIT'(1);
  localparam logic [PTR_BIT:0] CNT_ONE = (PTR_BIT + 1)'(1);

  logic [PTR_BIT-1:0] wptr, iptr, rsptr, rptr;
  logic [PTR_BIT:0]   cnt;
  logic [PTR_BIT:0]   unissued_cnt;
  logic [PTR_BIT:0]   outstanding_cnt;

  logic [BUF_DEPTH-1:0] live;
  logic [BUF_DEPTH-1:0] done;

  logic [INST_ID_BIT-1:0]    id_mem    [BUF_DEPTH];
  logic [ADDR_BIT-1:0]       addr_mem  [BUF_DEPTH];
  logic [REG_ID_BIT-1:0]     dst_mem   [BUF_DEPTH];
  logic [DATA_BIT-1:0]       data_mem  [BUF_DEPTH];
  logic [SPEC_LEVEL_BIT-1:0] spec_mem  [BUF_DEPTH];

  logic [SPEC_LEVEL_BIT-1:0] nxt_level   [SPEC_DEPTH+1];
  logic [SPEC_LEVEL_BIT-1:0] remap_level [BUF_DEPTH];

  logic alloc, issue, resp, retire, reclaim, pop;
  logic br_fail, br_succ;

  genvar gi;
  generate
    for (gi = 0; gi <= SPEC_DEPTH; gi++) begin : g_nxt
      assign nxt_level[gi] = br_pred_succ_nxt_levels[gi*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
    end
  endgenerate

  // Levels beyond SPEC_DEPTH cannot legally occur; they are left unchanged.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      remap_level[i] = spec_mem[i];
      for (int k = 0; k <= SPEC_DEPTH; k++) begin
        if (spec_mem[i] == SPEC_LEVEL_BIT'(k)) begin
          remap_level[i] = nxt_level[k];
        end
      end
    end
  end

  assign in_rdy       = (cnt < FULL_CNT);
  assign mem_req_vld  = (unissued_cnt != '0);
  assign mem_req_addr = addr_mem[iptr];

  assign out_vld  = (cnt != '0) && live[rptr] && done[rptr] && (spec_mem[rptr] == '0);
  assign out_id   = id_mem[rptr];
  assign out_dst  = dst_mem[rptr];
  assign out_data = data_mem[rptr];

  assign alloc   = in_vld && in_rdy;
  assign issue   = mem_req_vld && mem_req_rdy;
  // Responses with nothing outstanding are dropped so rsptr stays aligned with iptr.
  assign resp    = mem_resp_vld && (outstanding_cnt != '0);
  assign retire  = out_vld && out_rdy;
  assign reclaim = (cnt != '0) && !live[rptr] && done[rptr];
  assign pop     = retire || reclaim;
  assign br_fail = br_pred_vld && !br_pred_succ;
  assign br_succ = br_pred_vld && br_pred_succ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr            <= '0;
      iptr            <= '0;
      rsptr           <= '0;
      rptr            <= '0;
      cnt             <= '0;
      unissued_cnt    <= '0;
      outstanding_cnt <= '0;
    end else begin
      if (alloc) wptr <= wptr + PTR_ONE;
      if (issue) iptr <= iptr + PTR_ONE;
      if (resp)  rsptr <= rsptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;

      if (alloc && !pop)      cnt <= cnt + CNT_ONE;
      else if (!alloc && pop) cnt <= cnt - CNT_ONE;

      if (alloc && !issue)      unissued_cnt <= unissued_cnt + CNT_ONE;
      else if (!alloc && issue) unissued_cnt <= unissued_cnt - CNT_ONE;

      if (issue && !resp)      outstanding_cnt <= outstanding_cnt + CNT_ONE;
      else if (!issue && resp) outstanding_cnt <= outstanding_cnt - CNT_ONE;
    end
  end

  // A kill only clears live; done still tracks the in-flight read so the slot can be reclaimed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (alloc && (wptr == PTR_BIT'(i))) begin
          live[i] <= 1'b1;
          done[i] <= 1'b0;
        end else if (pop && (rptr == PTR_BIT'(i))) begin
          live[i] <= 1'b0;
          done[i] <= 1'b0;
        end else begin
          if (br_fail && live[i] && (spec_mem[i] >= br_pred_fail_level)) live[i] <= 1'b0;
          if (resp && (rsptr == PTR_BIT'(i))) done[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      id_mem[wptr]   <= in_id;
      addr_mem[wptr] <= in_addr;
      dst_mem[wptr]  <= in_dst;
    end
    if (resp) data_mem[rsptr] <= mem_resp_data;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (alloc && (wptr == PTR_BIT'(i))) begin
        spec_mem[i] <= in_spec_level;
      end else if (br_succ && live[i]) begin
        spec_mem[i] <= remap_level[i];
      end
    end
  end

endmodule

// File: tb/tb_load_buf.sv
// Directed bench for load_buf: a latency-programmable memory responder, a writeback
// monitor, and hand-computed expectations for each scenario.
module tb_load_buf;

  localparam int IB = 8, AB = 16, DB = 16, RB = 4, BD = 8, SD = 4, SLB = 3;

  logic              clk, rst_n;
  logic              in_vld, in_rdy;
  logic [IB-1:0]     in_id;
  logic [AB-1:0]     in_addr;
  logic [RB-1:0]     in_dst;
  logic [SLB-1:0]    in_spec_level;
  logic              mem_req_vld, mem_req_rdy;
  logic [AB-1:0]     mem_req_addr;
  logic              mem_resp_vld;
  logic [DB-1:0]     mem_resp_data;
  logic              out_vld, out_rdy;
  logic [IB-1:0]     out_id;
  logic [RB-1:0]     out_dst;
  logic [DB-1:0]     out_data;
  logic              br_pred_vld, br_pred_succ;
  logic [SLB-1:0]    br_pred_fail_level;
  logic [SLB*(SD+1)-1:0] br_pred_succ_nxt_levels;

  typedef struct packed {
    logic [IB-1:0] id;
    logic [RB-1:0] dst;
    logic [DB-1:0] data;
  } wb_t;

  wb_t            wb_q[$];
  logic [AB-1:0]  req_addr_q[$];
  int             req_due_q[$];
  int             checks = 0;
  int             failures = 0;
  int             mem_lat = 2;
  int             cyc = 0;

  load_buf #(
    .INST_ID_BIT(IB), .ADDR_BIT(AB), .DATA_BIT(DB), .REG_ID_BIT(RB),
    .BUF_DEPTH(BD), .SPEC_DEPTH(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id), .in_addr(in_addr),
    .in_dst(in_dst), .in_spec_level(in_spec_level),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_vld(mem_resp_vld), .mem_resp_data(mem_resp_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_dst(out_dst),
    .out_data(out_data),
    .br_pred_vld(br_pred_vld), .br_pred_succ(br_pred_succ),
    .br_pred_fail_level(br_pred_fail_level),
    .br_pred_succ_nxt_levels(br_pred_succ_nxt_levels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DB-1:0] mdata(input logic [AB-1:0] a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0020: return 16'h1234;
      default:  return a ^ 16'h5A00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wb_id(input int i);
    if (i < wb_q.size()) return 32'(wb_q[i].id);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wb_data(input int i);
    if (i < wb_q.size()) return 32'(wb_q[i].data);
    return 32'hFFFF_FFFF;
  endfunction

  // Memory: a request accepted at the edge after negedge c is answered in cycle c+mem_lat.
  initial begin
    mem_resp_vld  = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      mem_resp_vld  = 1'b0;
      mem_resp_data = '0;
      if (rst_n && req_due_q.size() > 0 && req_due_q[0] <= cyc) begin
        mem_resp_vld  = 1'b1;
        mem_resp_data = mdata(req_addr_q[0]);
        void'(req_addr_q.pop_front());
        void'(req_due_q.pop_front());
      end
      if (rst_n && mem_req_vld && mem_req_rdy) begin
        req_addr_q.push_back(mem_req_addr);
        req_due_q.push_back(cyc + mem_lat);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_vld && out_rdy) begin
        wb_q.push_back('{id: out_id, dst: out_dst, data: out_data});
        $display("wb id=%0d dst=%0d data=0x%04h", out_id, out_dst, out_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int id, input int a, input int d, input int l);
    int t = 0;
    in_vld        = 1'b1;
    in_id         = IB'(id);
    in_addr       = AB'(a);
    in_dst        = RB'(d);
    in_spec_level = SLB'(l);
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_rdy", 32'(in_rdy), 32'd1);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic branch(input logic succ, input int lvl);
    br_pred_vld        = 1'b1;
    br_pred_succ       = succ;
    br_pred_fail_level = SLB'(lvl);
    step(1);
    br_pred_vld = 1'b0;
  endtask

  task automatic wait_wb(input int n, input int budget);
    int t = 0;
    while (wb_q.size() < n && t < budget) begin
      step(1);
      t++;
    end
    check("wb_count", 32'(wb_q.size()), 32'(n));
  endtask

  initial begin
    int exp_id [17];
    rst_n = 1'b0;
    in_vld = 1'b0; in_id = '0; in_addr = '0; in_dst = '0; in_spec_level = '0;
    mem_req_rdy = 1'b1; out_rdy = 1'b1;
    br_pred_vld = 1'b0; br_pred_succ = 1'b0; br_pred_fail_level = '0;
    br_pred_succ_nxt_levels = '0;
    // Success map: level k -> k-1, level 0 stays 0.
    for (int k = 1; k <= SD; k++) br_pred_succ_nxt_levels[k*SLB +: SLB] = SLB'(k - 1);

    step(3);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_mem_req_vld", 32'(mem_req_vld), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single non-speculative load, 2-cycle memory.
    push(1, 'h0010, 3, 0);
    check("t1_req_vld", 32'(mem_req_vld), 32'd1);
    check("t1_req_addr", 32'(mem_req_addr), 32'h0010);
    step(2);
    check("t1_early_vld", 32'(out_vld), 32'd0);
    step(1);
    check("t1_out_vld", 32'(out_vld), 32'd1);
    check("t1_out_data", 32'(out_data), 32'hBEEF);
    check("t1_out_dst", 32'(out_dst), 32'd3);
    check("t1_out_id", 32'(out_id), 32'd1);
    step(2);

    // Speculative hold released by branch success.
    push(2, 'h0020, 4, 1);
    step(6);
    check("t2_hold", 32'(out_vld), 32'd0);
    branch(1'b1, 0);
    check("t2_out_vld", 32'(out_vld), 32'd1);
    check("t2_out_data", 32'(out_data), 32'h1234);
    check("t2_out_id", 32'(out_id), 32'd2);
    step(2);

    // Flush at level 2: level 0 and level 1 survive, level 2 entries vanish.
    wb_q.delete();
    push(10, 'h0030, 1, 0);
    push(11, 'h0031, 1, 2);
    push(13, 'h0038, 2, 1);
    push(12, 'h0032, 1, 2);
    step(8);
    branch(1'b0, 2);
    step(6);
    check("t3_wb_cnt", 32'(wb_q.size()), 32'd1);
    check("t3_wb_id0", wb_id(0), 32'd10);
    check("t3_hold_lvl1", 32'(out_vld), 32'd0);
    branch(1'b1, 0);
    check("t3_x_vld", 32'(out_vld), 32'd1);
    check("t3_x_id", 32'(out_id), 32'd13);
    check("t3_x_data", 32'(out_data), 32'h5A38);
    step(6);
    check("t3_wb_cnt2", 32'(wb_q.size()), 32'd2);

    // Kill an issued load before its slow response; younger load must get its own data.
    wb_q.delete();
    mem_lat = 5;
    push(20, 'h0040, 5, 1);
    branch(1'b0, 1);
    push(21, 'h0050, 6, 0);
    wait_wb(1, 40);
    check("t4_wb_id", wb_id(0), 32'd21);
    check("t4_wb_data", wb_data(0), 32'h5A50);
    step(8);
    check("t4_wb_cnt", 32'(wb_q.size()), 32'd1);
    mem_lat = 2;

    // Fill to full with memory stalled, then drain; batches straddle the pointer wrap.
    wb_q.delete();
    push(29, 'h00F0, 0, 0);
    wait_wb(1, 20);
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(30 + i, 'h0100 + i, i, 0);
    check("t5_full_in_rdy", 32'(in_rdy), 32'd0);
    check("t5_full_req_vld", 32'(mem_req_vld), 32'd1);
    mem_req_rdy = 1'b1;
    wait_wb(9, 100);
    for (int i = 0; i < 8; i++) push(40 + i, 'h0200 + i, i, 0);
    wait_wb(17, 100);
    exp_id[0] = 29;
    for (int i = 0; i < 8; i++) begin
      exp_id[1 + i] = 30 + i;
      exp_id[9 + i] = 40 + i;
    end
    for (int i = 0; i < 17; i++) check($sformatf("t5_order_%0d", i), wb_id(i), 32'(exp_id[i]));
    check("t5_data_first", wb_data(1), 32'h5B00);
    check("t5_data_last", wb_data(16), 32'h5807);

    // Writeback backpressure.
    wb_q.delete();
    out_rdy = 1'b0;
    push(50, 'h0300, 5, 0);
    push(51, 'h0301, 6, 0);
    push(52, 'h0302, 7, 0);
    step(8);
    check("t6_vld", 32'(out_vld), 32'd1);
    check("t6_id_a", 32'(out_id), 32'd50);
    step(3);
    check("t6_id_stable", 32'(out_id), 32'd50);
    check("t6_dst_stable", 32'(out_dst), 32'd5);
    out_rdy = 1'b1;
    check("t6_wb0", 32'(out_id), 32'd50);
    step(1);
    check("t6_wb1_vld", 32'(out_vld), 32'd1);
    check("t6_wb1", 32'(out_id), 32'd51);
    step(1);
    check("t6_wb2_vld", 32'(out_vld), 32'd1);
    check("t6_wb2", 32'(out_id), 32'd52);
    check("t6_wb2_data", 32'(out_data), 32'h5902);
    step(1);
    check("t6_empty", 32'(out_vld), 32'd0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
